fluxo_dados_jogo_param: RTL and testbench

Parametrised datapath for the sequence-memory game: address and limit counters, writable sequence memory, button register, comparators, press-edge detector and timeout counter. Generalises the fixed 4-button / 16-entry / ROM datapath with configurable button count, depth and timeout. Adds a record mode that writes the player's move into memory, a one-hot move-validity check, and a correct strict "address < limit" compare. It sits under the game control unit, which drives all conta/zera/registra/escreve strobes.

---
 rtl/fluxo_dados_jogo_param.sv | 98 +++++++++
 tb/tb_fluxo_dados_jogo_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fluxo_dados_jogo_param.sv
// fluxo_dados_jogo_param: parametrised datapath for the sequence-memory game
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   botoes                        synchronised button levels
//   zeraR/registraR               clear/load the button register
//   zeraE/contaE, zeraL/contaL    clear/increment address and limit counters
//   escreveM                      write button register into mem[endereco]
//   zeraT/contaT                  clear/enable the timeout counter
//   chavesIgualMemoria, enderecoIgualLimite, enderecoMenorLimite, fimE, fimL,
//   jogada_feita, jogada_valida, timeout   status to the control unit
//   db_*                          debug views of internal state
module fluxo_dados_jogo_param #(
    parameter int NBOT    = 4,
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int TIMEOUT = 3000,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NBOT-1:0] botoes,
    input  logic            zeraR,
    input  logic            registraR,
    input  logic            zeraE,
    input  logic            contaE,
    input  logic            zeraL,
    input  logic            contaL,
    input  logic            escreveM,
    input  logic            zeraT,
    input  logic            contaT,
    output logic            chavesIgualMemoria,
    output logic            enderecoIgualLimite,
    output logic            enderecoMenorLimite,
    output logic            fimE,
    output logic            fimL,
    output logic            jogada_feita,
    output logic            jogada_valida,
    output logic            timeout,
    output logic            db_tem_jogada,
    output logic [AW-1:0]   db_contagem,
    output logic [AW-1:0]   db_limite,
    output logic [NBOT-1:0] db_jogada,
    output logic [NBOT-1:0] db_memoria,
    output logic [TW-1:0]   db_timeout
);
    logic [AW-1:0]   endereco, limite;
    logic [NBOT-1:0] jogada, rdata;
    logic [NBOT-1:0] mem [DEPTH];
    logic            prev;
    logic [TW-1:0]   tcnt;
    logic            limpa_t;

    assign fimE                = endereco == AW'(DEPTH - 1);
    assign fimL                = limite == AW'(DEPTH - 1);
    assign enderecoIgualLimite = endereco == limite;
    assign enderecoMenorLimite = endereco < limite;
    assign chavesIgualMemoria  = jogada == rdata;
    assign jogada_valida       = $onehot(jogada);
    assign db_tem_jogada       = |botoes;
    assign jogada_feita        = db_tem_jogada & ~prev;
    // any address movement or a fresh press restarts the wait for a move
    assign limpa_t             = zeraT | contaE | zeraE | jogada_feita;
    assign db_contagem         = endereco;
    assign db_limite           = limite;
    assign db_jogada           = jogada;
    assign db_memoria          = rdata;
    assign db_timeout          = tcnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            endereco <= '0;
            limite   <= '0;
            jogada   <= '0;
            rdata    <= '0;
            prev     <= 1'b0;
            tcnt     <= '0;
            timeout  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (zeraE) endereco <= '0;
            else if (contaE) endereco <= fimE ? '0 : endereco + 1'b1;
            if (zeraL) limite <= '0;
            else if (contaL) limite <= fimL ? '0 : limite + 1'b1;
            if (zeraR) jogada <= '0;
            else if (registraR) jogada <= botoes;
            // old register value and pre-increment address are used on collisions
            if (escreveM) mem[endereco] <= jogada;
            rdata <= mem[endereco];
            prev  <= db_tem_jogada;
            if (limpa_t) begin
                tcnt    <= '0;
                timeout <= 1'b0;
            end else if (contaT & ~db_tem_jogada & ~timeout) begin
                tcnt    <= (tcnt == TW'(TIMEOUT - 1)) ? '0 : tcnt + 1'b1;
                timeout <= tcnt == TW'(TIMEOUT - 1);
            end
        end
    end
endmodule

// File: tb/tb_fluxo_dados_jogo_param.sv
// tb_fluxo_dados_jogo_param: scoreboard bench for fluxo_dados_jogo_param
module tb_fluxo_dados_jogo_param;
    localparam int NBOT = 4, DEPTH = 16, AW = 4, TIMEOUT = 8, TW = 4;
    localparam int S_CIM = 0, S_EIL = 1, S_EML = 2, S_FIME = 3, S_FIML = 4, S_JF = 5,
                   S_JV = 6, S_TO = 7, S_TEM = 8, S_CNT = 9, S_LIM = 10, S_JOG = 11,
                   S_MEM = 12, S_TCNT = 13;

    logic clock = 1'b0, reset = 1'b1;
    logic [NBOT-1:0] botoes = '0;
    logic zeraR = 0, registraR = 0, zeraE = 0, contaE = 0, zeraL = 0, contaL = 0;
    logic escreveM = 0, zeraT = 0, contaT = 0;
    logic chavesIgualMemoria, enderecoIgualLimite, enderecoMenorLimite, fimE, fimL;
    logic jogada_feita, jogada_valida, timeout, db_tem_jogada;
    logic [AW-1:0] db_contagem, db_limite;
    logic [NBOT-1:0] db_jogada, db_memoria;
    logic [TW-1:0] db_timeout;

    fluxo_dados_jogo_param #(.NBOT(NBOT), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .botoes(botoes), .zeraR(zeraR), .registraR(registraR),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL), .escreveM(escreveM),
        .zeraT(zeraT), .contaT(contaT), .chavesIgualMemoria(chavesIgualMemoria),
        .enderecoIgualLimite(enderecoIgualLimite), .enderecoMenorLimite(enderecoMenorLimite),
        .fimE(fimE), .fimL(fimL), .jogada_feita(jogada_feita), .jogada_valida(jogada_valida),
        .timeout(timeout), .db_tem_jogada(db_tem_jogada), .db_contagem(db_contagem),
        .db_limite(db_limite), .db_jogada(db_jogada), .db_memoria(db_memoria),
        .db_timeout(db_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       nm;
    } chk_t;

    chk_t q[$];
    int checks = 0, errors = 0;

    function automatic logic [31:0] valor(int sel);
        case (sel)
            S_CIM:   return 32'(chavesIgualMemoria);
            S_EIL:   return 32'(enderecoIgualLimite);
            S_EML:   return 32'(enderecoMenorLimite);
            S_FIME:  return 32'(fimE);
            S_FIML:  return 32'(fimL);
            S_JF:    return 32'(jogada_feita);
            S_JV:    return 32'(jogada_valida);
            S_TO:    return 32'(timeout);
            S_TEM:   return 32'(db_tem_jogada);
            S_CNT:   return 32'(db_contagem);
            S_LIM:   return 32'(db_limite);
            S_JOG:   return 32'(db_jogada);
            S_MEM:   return 32'(db_memoria);
            default: return 32'(db_timeout);
        endcase
    endfunction

    task automatic espera(int sel, logic [31:0] exp, string nm);
        chk_t c;
        c.sel = sel;
        c.exp = exp;
        c.nm  = nm;
        q.push_back(c);
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    always @(negedge clock) begin
        while (q.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c = q.pop_front();
            act = valor(c.sel);
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h at %0t", c.nm, act, c.exp, $time);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        reset = 0;
        tick(5);
        espera(S_CNT, 0, "rst_cnt");
        espera(S_LIM, 0, "rst_lim");
        espera(S_JOG, 0, "rst_jog");
        espera(S_MEM, 0, "rst_mem");
        espera(S_TCNT, 0, "rst_tcnt");
        espera(S_TO, 0, "rst_to");
        espera(S_EIL, 1, "rst_eil");
        espera(S_EML, 0, "rst_eml");
        espera(S_FIME, 0, "rst_fime");
        espera(S_JF, 0, "rst_jf");
        espera(S_JV, 0, "rst_jv");

        contaE = 1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            espera(S_CNT, 32'(i % 16), $sformatf("wrap_cnt%0d", i));
            espera(S_FIME, 32'(i % 16 == 15), $sformatf("wrap_fim%0d", i));
        end
        contaE = 0;

        zeraE = 1; tick(); zeraE = 0;
        botoes = 4'b0100; registraR = 1; tick(); registraR = 0; botoes = 0;
        espera(S_JOG, 4'b0100, "rec_jog");
        escreveM = 1; tick(); escreveM = 0;
        contaE = 1; tick(3); contaE = 0;
        espera(S_CNT, 3, "rec_addr3");
        escreveM = 1; tick(); escreveM = 0;
        espera(S_MEM, 0, "rdw_old");
        tick();
        espera(S_MEM, 4'b0100, "rec_read3");
        espera(S_CIM, 1, "rec_cim");

        zeraE = 1; tick(); zeraE = 0;
        botoes = 4'b0001; registraR = 1; escreveM = 1; contaE = 1;
        tick();
        registraR = 0; escreveM = 0; contaE = 0; botoes = 0;
        espera(S_CNT, 1, "sim_cnt");
        espera(S_JOG, 4'b0001, "sim_jog");
        zeraE = 1; tick(); zeraE = 0; tick();
        espera(S_MEM, 4'b0100, "sim_mem0_oldreg");
        espera(S_CIM, 0, "sim_cim");
        contaE = 1; tick(); contaE = 0; tick();
        espera(S_MEM, 0, "sim_mem1_untouched");

        tick();
        botoes = 4'b0010;
        espera(S_JF, 1, "edge_pulse");
        espera(S_TEM, 1, "edge_tem");
        for (int i = 0; i < 10; i++) begin
            tick();
            espera(S_JF, 0, $sformatf("edge_hold%0d", i));
        end
        botoes = 4'b0011;
        espera(S_JF, 0, "edge_change");
        registraR = 1; tick(); registraR = 0;
        espera(S_JOG, 4'b0011, "jv_jog");
        espera(S_JV, 0, "jv_two_bits");
        botoes = 4'b0010; registraR = 1; tick(); registraR = 0;
        espera(S_JV, 1, "jv_one_bit");
        botoes = 0; tick();

        zeraT = 1; tick(); zeraT = 0;
        contaT = 1;
        espera(S_TCNT, 0, "to_clr");
        for (int i = 1; i <= 8; i++) begin
            tick();
            espera(S_TO, 32'(i == 8), $sformatf("to_flag%0d", i));
            espera(S_TCNT, 32'(i % 8), $sformatf("to_cnt%0d", i));
        end
        tick(3);
        espera(S_TO, 1, "to_sticky");
        espera(S_TCNT, 0, "to_frozen");
        contaE = 1; tick(); contaE = 0;
        espera(S_TO, 0, "to_cleared_contaE");
        tick(5);
        espera(S_TCNT, 5, "to_cnt5");
        botoes = 4'b0001; tick();
        espera(S_TCNT, 0, "to_press_clr");
        tick();
        espera(S_TCNT, 0, "to_held_nocount");
        botoes = 0;
        tick(7);
        espera(S_TCNT, 7, "to_restart7");
        espera(S_TO, 0, "to_restart_low");
        tick();
        espera(S_TO, 1, "to_restart_high");
        contaT = 0; zeraT = 1; tick(); zeraT = 0;
        espera(S_TO, 0, "to_zeraT");

        zeraE = 1; zeraL = 1; tick(); zeraE = 0; zeraL = 0;
        contaL = 1; tick(3); contaL = 0;
        espera(S_LIM, 3, "lim3");
        espera(S_FIML, 0, "lim3_fim");
        for (int i = 0; i <= 4; i++) begin
            espera(S_CNT, 32'(i), $sformatf("cmp_addr%0d", i));
            espera(S_EML, 32'(i < 3), $sformatf("cmp_menor%0d", i));
            espera(S_EIL, 32'(i == 3), $sformatf("cmp_igual%0d", i));
            contaE = 1; tick(); contaE = 0;
        end
        zeraE = 1; contaE = 1; tick(); zeraE = 0; contaE = 0;
        espera(S_CNT, 0, "zera_over_conta");
        contaL = 1; tick(12); contaL = 0;
        espera(S_FIML, 1, "lim15_fim");
        contaL = 1; tick(); contaL = 0;
        espera(S_LIM, 0, "lim_wrap");

        reset = 1; tick(); reset = 0; tick(2);
        espera(S_MEM, 0, "rst_clears_mem0");
        espera(S_CNT, 0, "rst_cnt2");
        tick(2);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
